// File: rtl/ram_wr_ctrl.sv
// rtl/ram_wr_ctrl.sv - fill-and-playback address/data sequencer for an 8x256 single-port RAM
module ram_wr_ctrl #(
    parameter logic [23:0] CNT_MAX     = 24'd9_999_999,
    parameter logic [7:0]  DATA_OFFSET = 8'd0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key1_flag,
    input  logic       key2_flag,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] addr,
    output logic [7:0] wr_data,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t      state;
    logic [23:0] cnt;

    assign mode = state;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            addr    <= 8'd0;
            wr_data <= 8'd0;
            cnt     <= 24'd0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key1_flag) begin
                        state   <= WRITE;
                        addr    <= 8'd0;
                        cnt     <= 24'd0;
                        wr_en   <= 1'b1;
                        rd_en   <= 1'b0;
                        wr_data <= DATA_OFFSET;
                    end
                end
                WRITE: begin
                    if (addr == 8'd255) begin
                        state <= READ;
                        wr_en <= 1'b0;
                        rd_en <= 1'b1;
                        addr  <= 8'd0;
                        cnt   <= 24'd0;
                    end else begin
                        addr    <= addr + 8'd1;
                        // data tracks the address it is written with, not the old one
                        wr_data <= addr + 8'd1 + DATA_OFFSET;
                    end
                end
                READ: begin
                    if (key1_flag) begin
                        state   <= WRITE;
                        addr    <= 8'd0;
                        cnt     <= 24'd0;
                        wr_en   <= 1'b1;
                        rd_en   <= 1'b0;
                        wr_data <= DATA_OFFSET;
                    end else if (key2_flag) begin
                        state <= PAUSE;
                    end else if (cnt == CNT_MAX) begin
                        cnt  <= 24'd0;
                        addr <= addr + 8'd1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                PAUSE: begin
                    // addr and cnt stay frozen so resuming finishes the interrupted dwell
                    if (key1_flag) begin
                        state   <= WRITE;
                        addr    <= 8'd0;
                        cnt     <= 24'd0;
                        wr_en   <= 1'b1;
                        rd_en   <= 1'b0;
                        wr_data <= DATA_OFFSET;
                    end else if (key2_flag) begin
                        state <= READ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wr_ctrl.sv
// tb/tb_ram_wr_ctrl.sv - scoreboard bench for ram_wr_ctrl with a behavioural playback model
module tb_ram_wr_ctrl;

    localparam int CMAX = 4;
    localparam int OFS  = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key1_flag = 1'b0;
    logic       key2_flag = 1'b0;
    logic       wr_en, rd_en;
    logic [7:0] addr, wr_data;
    logic [1:0] mode;

    ram_wr_ctrl #(.CNT_MAX(24'd4), .DATA_OFFSET(8'd10)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .key1_flag(key1_flag), .key2_flag(key2_flag),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .mode(mode)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int m;
        int a;
        int d;
        int we;
        int re;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // model state: mode 0 idle, 1 write, 2 read, 3 pause
    int m_mode = 0, m_addr = 0, m_data = 0, m_cnt = 0;
    int write_count = 0;

    task automatic model_step(input bit rst_n, input bit k1, input bit k2);
        if (!rst_n) begin
            m_mode = 0; m_addr = 0; m_data = 0; m_cnt = 0;
        end else if (k1 && m_mode != 1) begin
            m_mode = 1; m_addr = 0; m_cnt = 0; m_data = OFS % 256;
        end else if (m_mode == 1) begin
            if (m_addr == 255) begin
                m_mode = 2; m_addr = 0; m_cnt = 0;
            end else begin
                m_addr = m_addr + 1;
                m_data = (m_addr + OFS) % 256;
            end
        end else if (m_mode == 2) begin
            if (k2) m_mode = 3;
            else if (m_cnt == CMAX) begin
                m_cnt = 0; m_addr = (m_addr + 1) % 256;
            end else m_cnt = m_cnt + 1;
        end else if (m_mode == 3) begin
            if (k2) m_mode = 2;
        end
    endtask

    task automatic cyc(input bit rst_n, input bit k1, input bit k2);
        exp_t e;
        sys_rst_n = rst_n;
        key1_flag = k1;
        key2_flag = k2;
        @(posedge sys_clk);
        model_step(rst_n, k1, k2);
        e.m  = m_mode;
        e.a  = m_addr;
        e.d  = m_data;
        e.we = (m_mode == 1) ? 1 : 0;
        e.re = (m_mode >= 2) ? 1 : 0;
        q.push_back(e);
        #1;
        sys_rst_n = 1'b1;
        key1_flag = 1'b0;
        key2_flag = 1'b0;
    endtask

    task automatic idle_until(input int want_mode, input int want_addr, input int want_cnt,
                              input int budget, input string name);
        int n = 0;
        while (!(m_mode == want_mode && (want_addr < 0 || m_addr == want_addr) &&
                 (want_cnt < 0 || m_cnt == want_cnt)) && n < budget) begin
            cyc(1, 0, 0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles (mode %0d addr %0d)", name, n, m_mode, m_addr);
        end
    endtask

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (int'(mode) != e.m || int'(addr) != e.a || int'(wr_data) != e.d ||
                int'(wr_en) != e.we || int'(rd_en) != e.re) begin
                failures++;
                $display("FAIL cycle@%0t: got mode=%0d addr=%0d wr_data=%0d wr_en=%0d rd_en=%0d, want mode=%0d addr=%0d wr_data=%0d wr_en=%0d rd_en=%0d",
                         $time, mode, addr, wr_data, wr_en, rd_en, e.m, e.a, e.d, e.we, e.re);
            end
            if (wr_en && rd_en) begin
                failures++;
                $display("FAIL exclusive_en@%0t: wr_en=1 rd_en=1, want not both", $time);
            end
            if (wr_en) write_count++;
        end
    end

    initial begin
        int w0;
        repeat (3) cyc(0, 0, 0);
        repeat (3) cyc(1, 0, 1);
        // first fill, then watch a full playback lap including 255 -> 0
        w0 = write_count;
        cyc(1, 1, 0);
        idle_until(2, 0, 0, 300, "fill1_done");
        @(negedge sys_clk); #1;
        checks++;
        if (write_count - w0 != 256) begin
            failures++;
            $display("FAIL fill1_count: got %0d writes, want 256", write_count - w0);
        end
        repeat (256 * 5 + 20) cyc(1, 0, 0);
        // pause at addr 7 / cnt 2, hold, resume
        idle_until(2, 7, 2, 2000, "reach_addr7");
        cyc(1, 0, 1);
        repeat (100) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (10) cyc(1, 0, 0);
        // restart at addr 40 with keys pulsed mid-write
        idle_until(2, 40, -1, 2000, "reach_addr40");
        w0 = write_count;
        cyc(1, 1, 0);
        repeat (50) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (20) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        idle_until(2, 0, 0, 300, "fill2_done");
        @(negedge sys_clk); #1;
        checks++;
        if (write_count - w0 != 256) begin
            failures++;
            $display("FAIL fill2_count: got %0d writes, want 256", write_count - w0);
        end
        // simultaneous keys during pause: key1 wins
        repeat (3) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 1);
        // reset mid-write at addr 100
        idle_until(1, 100, -1, 300, "reach_wr100");
        cyc(0, 0, 0);
        repeat (5) cyc(1, 0, 1);
        // randomized keys and occasional reset
        for (int i = 0; i < 4000; i++) begin
            bit r, k1, k2;
            r  = ($urandom_range(0, 799) != 0);
            k1 = ($urandom_range(0, 399) == 0);
            k2 = ($urandom_range(0, 29) == 0);
            cyc(r, k1, k2);
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
